// File: rtl/mpseq_pkg.sv
// Shared types and constants for the multi-precision ALU sequencer.
package mpseq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [2:0] OP_PASS = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_ADDN = 3'd2;
  localparam logic [2:0] OP_DEC  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_NOT  = 3'd7;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 3;

  function automatic logic [3:0] pack_flags(input logic v, input logic n, input logic z,
                                            input logic c);
    logic [3:0] r;
    r         = '0;
    r[FLAG_V] = v;
    r[FLAG_N] = n;
    r[FLAG_Z] = z;
    r[FLAG_C] = c;
    return r;
  endfunction

endpackage

// File: rtl/alu_flags.sv
// N-bit ALU slice: arithmetic ops add A to a per-op Y plus cin; logic ops force C and V to 0.
module alu_flags
  import mpseq_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   h,
  input  logic         cin,
  output logic [N-1:0] f,
  output logic [3:0]   flags
);

  logic [N-1:0] y;
  logic [N:0]   sum;
  logic         arith;

  always_comb begin
    y     = '0;
    arith = 1'b1;
    f     = '0;
    case (h)
      OP_PASS: y = '0;
      OP_ADD:  y = b;
      OP_ADDN: y = ~b;
      OP_DEC:  y = '1;
      default: arith = 1'b0;
    endcase
    sum = {1'b0, a} + {1'b0, y} + {{N{1'b0}}, cin};
    case (h)
      OP_AND:  f = a & b;
      OP_OR:   f = a | b;
      OP_XOR:  f = a ^ b;
      OP_NOT:  f = ~a;
      default: f = sum[N-1:0];
    endcase
    // Signed overflow: operands agree in sign but the result does not.
    flags = pack_flags(arith & (a[N-1] == y[N-1]) & (f[N-1] != a[N-1]),
                       f[N-1], (f == '0), arith & sum[N]);
  end

endmodule

// File: rtl/mpseq_alu_ctrl.sv
// Sequences one alu_flags slice over WORDS words, LSB first, chaining carry between words.
// Optional MPSEQ_LOGIC_FAST_EN: logic ops (4-7) complete in a single full-width RUN cycle.
module mpseq_alu_ctrl
  import mpseq_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_op,
  input  logic               req_cin,
  input  logic [N*WORDS-1:0] req_a,
  input  logic [N*WORDS-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [N*WORDS-1:0] rsp_f,
  output logic [3:0]         rsp_flags,
  output logic               busy
);

  localparam int unsigned W    = N * WORDS;
  localparam int unsigned IW   = $clog2(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic [2:0]    op_q;
  logic          cin_q, carry_q, zacc_q;
  logic [W-1:0]  a_q, b_q, acc_q, acc_nxt;

  logic [N-1:0]  s_a, s_b, s_f;
  logic          s_cin;
  logic [3:0]    s_flags;

  assign s_a   = a_q[int'(idx_q) * N +: N];
  assign s_b   = b_q[int'(idx_q) * N +: N];
  assign s_cin = (idx_q == '0) ? cin_q : carry_q;

  alu_flags #(.N(N)) u_slice (
    .a     (s_a),
    .b     (s_b),
    .h     (op_q),
    .cin   (s_cin),
    .f     (s_f),
    .flags (s_flags)
  );

  always_comb begin
    acc_nxt = acc_q;
    acc_nxt[int'(idx_q) * N +: N] = s_f;
  end

`ifdef MPSEQ_LOGIC_FAST_EN
  logic [W-1:0] fast_f;

  always_comb begin
    fast_f = '0;
    case (op_q)
      OP_AND:  fast_f = a_q & b_q;
      OP_OR:   fast_f = a_q | b_q;
      OP_XOR:  fast_f = a_q ^ b_q;
      default: fast_f = ~a_q;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      op_q      <= OP_PASS;
      cin_q     <= 1'b0;
      carry_q   <= 1'b0;
      zacc_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      rsp_f     <= '0;
      rsp_flags <= '0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            cin_q     <= req_cin;
            a_q       <= req_a;
            b_q       <= req_b;
            idx_q     <= '0;
            zacc_q    <= 1'b1;
            state_q   <= RUN;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        RUN: begin
`ifdef MPSEQ_LOGIC_FAST_EN
          if (op_q[2]) begin
            rsp_f     <= fast_f;
            rsp_flags <= pack_flags(1'b0, fast_f[W-1], (fast_f == '0), 1'b0);
            rsp_valid <= 1'b1;
            state_q   <= DONE;
          end else
`endif
          begin
            acc_q   <= acc_nxt;
            carry_q <= s_flags[FLAG_C];
            zacc_q  <= zacc_q & s_flags[FLAG_Z];
            if (idx_q == LAST) begin
              // Result is published only here, so a reset mid-RUN never exposes partial words.
              rsp_f     <= acc_nxt;
              rsp_flags <= pack_flags(s_flags[FLAG_V], s_flags[FLAG_N],
                                      zacc_q & s_flags[FLAG_Z], s_flags[FLAG_C]);
              rsp_valid <= 1'b1;
              state_q   <= DONE;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
